// File: rtl/std_spi_mem_master.sv
// std_spi_mem_master
//   SPI initiator for a 48-bit register-memory SPI target. Takes one command
//   at a time (read/write, address, write data) and serialises the frame
//   {rw, 1'b0, addr, data} MSB-first. During reads it captures miso over the
//   data bits and returns them with a one-cycle response pulse. It supports
//   all four CPOL/CPHA modes, latched when a command is accepted.
//
//   Ports
//     clk, rst_n             system clock, async active-low reset
//     cpol, cpha             SPI mode, latched at command accept
//     cmd_valid/cmd_ready    command handshake (ready only while idle)
//     cmd_rw/addr/wdata      command fields (rw: 1 = write)
//     rsp_valid/rw/rdata     completion pulse, rw echo, read data (held)
//     busy                   accept through end of the inter-frame gap
//     sclk, cs_n, mosi, miso SPI pins
//
//   state  | meaning
//   S_IDLE | cmd_ready high, sclk tracks cpol, waiting for a command
//   S_LEAD | cs_n low, sclk idle, CS_LEAD cycles before the first edge
//   S_XFER | sclk toggles every HALF_DIV cycles, 2*frame-bits edges total
//   S_LAG  | sclk idle, CS_LAG cycles, then cs_n rises and response fires
//   S_GAP  | cs_n high for CS_IDLE cycles before the next command
module std_spi_mem_master #(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 48,
   parameter int HALF_DIV  = 4,
   parameter int CS_LEAD   = 4,
   parameter int CS_LAG    = 4,
   parameter int CS_IDLE   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_rw,
   input  logic [ADDR_BITS-1:0] cmd_addr,
   input  logic [DATA_BITS-1:0] cmd_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_rw,
   output logic [DATA_BITS-1:0] rsp_rdata,
   output logic                 busy,
   output logic                 sclk,
   output logic                 cs_n,
   output logic                 mosi,
   input  logic                 miso
);

   localparam int HDR_BITS   = 2 + ADDR_BITS;
   localparam int FRAME_BITS = HDR_BITS + DATA_BITS;
   localparam int EDGES      = 2 * FRAME_BITS;
   localparam int EC_W       = $clog2(EDGES + 1);
   localparam int HD_W       = $clog2(HALF_DIV);
   localparam int PH_MAX     = (CS_LEAD > CS_LAG) ?
                               ((CS_LEAD > CS_IDLE) ? CS_LEAD : CS_IDLE) :
                               ((CS_LAG  > CS_IDLE) ? CS_LAG  : CS_IDLE);
   localparam int PH_W       = $clog2(PH_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_XFER,
      S_LAG,
      S_GAP
   } state_t;

   state_t                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic                   cpha_q, cpha_d;
   logic                   rw_q, rw_d;
   logic [FRAME_BITS-1:0]  tx_q, tx_d;
   logic [DATA_BITS-1:0]   rx_q, rx_d;
   logic [HD_W-1:0]        half_q, half_d;
   logic [EC_W-1:0]        edge_q, edge_d;
   logic [PH_W-1:0]        phase_q, phase_d;
   logic                   sclk_q, sclk_d;
   logic                   cs_n_q, cs_n_d;
   logic                   mosi_q, mosi_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_rw_q, rsp_rw_d;
   logic [DATA_BITS-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [FRAME_BITS-1:0]  frame;

   assign frame     = {cmd_rw, 1'b0, cmd_addr, (cmd_rw ? cmd_wdata : {DATA_BITS{1'b0}})};
   assign cmd_ready = ready_q & (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign sclk      = sclk_q;
   assign cs_n      = cs_n_q;
   assign mosi      = mosi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rw    = rsp_rw_q;
   assign rsp_rdata = rsp_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         cpha_q      <= 1'b0;
         rw_q        <= 1'b0;
         tx_q        <= '0;
         rx_q        <= '0;
         half_q      <= '0;
         edge_q      <= '0;
         phase_q     <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rw_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         cpha_q      <= cpha_d;
         rw_q        <= rw_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         half_q      <= half_d;
         edge_q      <= edge_d;
         phase_q     <= phase_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rw_q    <= rsp_rw_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b1;
      cpha_d      = cpha_q;
      rw_d        = rw_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      half_d      = half_q;
      edge_d      = edge_q;
      phase_d     = phase_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_rw_d    = rsp_rw_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         S_IDLE: begin
            sclk_d = cpol;
            if (cmd_valid && cmd_ready) begin
               cpha_d  = cpha;
               rw_d    = cmd_rw;
               // MSB goes out now; with cpha=0 the shift register already
               // points at bit 1, with cpha=1 edge 1 re-presents bit 0.
               tx_d    = cpha ? frame : (frame << 1);
               mosi_d  = frame[FRAME_BITS-1];
               cs_n_d  = 1'b0;
               rx_d    = '0;
               half_d  = '0;
               edge_d  = '0;
               phase_d = '0;
               state_d = S_LEAD;
            end
         end

         S_LEAD: begin
            if (phase_q == PH_W'(CS_LEAD - 1)) begin
               phase_d = '0;
               state_d = S_XFER;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         S_XFER: begin
            if (half_q == HD_W'(HALF_DIV - 1)) begin
               half_d = '0;
               sclk_d = ~sclk_q;
               edge_d = edge_q + 1'b1;
               // edge_q is the zero-based edge number: even = leading edge.
               // Sample edges are leading for cpha=0, trailing for cpha=1.
               if (edge_q[0] == cpha_q) begin
                  // miso is taken in the cycle just before the sample toggle;
                  // header bits occupy the first 2*HDR_BITS edges.
                  if (edge_q >= EC_W'(2 * HDR_BITS)) begin
                     rx_d = {rx_q[DATA_BITS-2:0], miso};
                  end
               end else if (edge_q != EC_W'(EDGES - 1)) begin
                  mosi_d = tx_q[FRAME_BITS-1];
                  tx_d   = tx_q << 1;
               end
               if (edge_q == EC_W'(EDGES - 1)) begin
                  state_d = S_LAG;
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         S_LAG: begin
            if (phase_q == PH_W'(CS_LAG - 1)) begin
               phase_d     = '0;
               cs_n_d      = 1'b1;
               mosi_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rw_d    = rw_q;
               if (!rw_q) begin
                  rsp_rdata_d = rx_q;
               end
               state_d     = S_GAP;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         S_GAP: begin
            if (phase_q == PH_W'(CS_IDLE - 1)) begin
               phase_d = '0;
               state_d = S_IDLE;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_std_spi_mem_master.sv
// Bench for std_spi_mem_master: a behavioural SPI register-memory target
// driven purely by sclk/cs_n edges, a table of write/read commands across
// all four modes, a back-to-back burst, and a mid-frame reset.
module tb_std_spi_mem_master;

   localparam int CS_IDLE   = 8;
   localparam int FRAME_CLK = 489;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpol, cpha, cmd_valid, cmd_rw;
   logic [9:0]  cmd_addr;
   logic [47:0] cmd_wdata;
   logic        cmd_ready, rsp_valid, rsp_rw, busy, sclk, cs_n, mosi;
   logic [47:0] rsp_rdata;
   logic        miso;

   std_spi_mem_master dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpol      (cpol),
      .cpha      (cpha),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rw    (cmd_rw),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rw    (rsp_rw),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural SPI target ----------------
   logic [47:0] mem [0:1023];
   logic        s_cpol = 1'b0, s_cpha = 1'b0;
   logic        s_prev_cs = 1'b1, s_prev_sclk = 1'b0, s_init = 1'b0, s_lead;
   logic [59:0] s_sh = '0;
   logic [11:0] s_hdr = '0, s_hdr_last = '0;
   logic [47:0] s_word, s_data_last = '0, wr_data = '0;
   logic [9:0]  wr_addr = '0;
   int          s_n = 0, s_edges = 0, s_edges_last = 0, wr_cnt = 0;

   always @(sclk or cs_n) begin
      if (cs_n !== s_prev_cs) begin
         if (cs_n === 1'b0) begin
            if (!s_init) begin
               for (int i = 0; i < 1024; i++) mem[i] = '0;
               s_init = 1'b1;
            end
            s_n = 0; s_edges = 0; s_sh = '0; s_hdr = '0; miso = 1'b0;
         end else if (cs_n === 1'b1 && s_prev_cs === 1'b0) begin
            s_edges_last = s_edges;
            s_hdr_last   = s_hdr;
            s_data_last  = s_sh[47:0];
            if (s_n == 60 && s_hdr[11]) begin
               mem[s_hdr[9:0]] = s_sh[47:0];
               wr_addr = s_hdr[9:0];
               wr_data = s_sh[47:0];
               wr_cnt++;
            end
         end
         s_prev_cs = cs_n;
      end else if (sclk !== s_prev_sclk && cs_n === 1'b0) begin
         s_edges++;
         s_lead = (sclk !== s_cpol);
         if (s_lead ^ s_cpha) begin
            s_sh = {s_sh[58:0], mosi};
            s_n++;
            if (s_n == 12) s_hdr = s_sh[11:0];
         end else if (s_n >= 12 && s_n < 60 && !s_hdr[11]) begin
            s_word = mem[s_hdr[9:0]];
            miso   = s_word[59 - s_n];
         end
      end
      s_prev_sclk = sclk;
   end

   // ---------------- continuous monitors ----------------
   logic m_cpol = 1'b0;
   logic prev_cs_m = 1'b1, seen_fall = 1'b0;
   int   rsp_cnt = 0, idle_err = 0, ready_err = 0, cs_hi_run = 0, min_gap = 1000;
   int   rsp_log [16];

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         rsp_log[rsp_cnt % 16] = cyc;
         rsp_cnt++;
      end
      if (rst_n && cs_n && busy && (sclk !== m_cpol)) idle_err++;
      if (cmd_ready && busy) ready_err++;
      if (cs_n) cs_hi_run++;
      else if (prev_cs_m) begin
         if (seen_fall && cs_hi_run < min_gap) min_gap = cs_hi_run;
         seen_fall = 1'b1;
         cs_hi_run = 0;
      end
      prev_cs_m = cs_n;
   end

   // ---------------- command driver ----------------
   task automatic do_cmd(input logic [1:0] mode, input logic rw, input logic [9:0] addr,
                         input logic [47:0] wd, output int len, output logic got_rw,
                         output logic [47:0] got_rd, output logic pulse1);
      int t;
      int acc;
      @(negedge clk);
      m_cpol = mode[1]; s_cpol = mode[1]; s_cpha = mode[0];
      cpol = mode[1]; cpha = mode[0];
      @(negedge clk);
      cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      chk("accept_wait", 64'(cmd_ready), 64'd1);
      acc = cyc;
      @(negedge clk);
      // Mid-frame input changes must have no effect.
      cmd_valid = 1'b0; cpol = ~mode[1]; cpha = ~mode[0];
      cmd_addr = ~addr; cmd_wdata = '1;
      t = 0;
      while (rsp_valid !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
      chk("rsp_wait", 64'(rsp_valid), 64'd1);
      len    = cyc - acc;
      got_rw = rsp_rw;
      got_rd = rsp_rdata;
      @(negedge clk);
      pulse1 = (rsp_valid === 1'b0);
      t = 0;
      while (busy && t < 100) begin @(negedge clk); t++; end
      chk("busy_drop", 64'(busy), 64'd0);
      cpol = mode[1]; cpha = mode[0];
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic        rw;
      logic [9:0]  addr;
      logic [47:0] wdata;
      logic [47:0] exp_rdata;
   } vec_t;

   vec_t        vecs [9];
   int          len, wr0, rsp0, idle0, t, k;
   int          acc [3];
   logic        got_rw, pulse1;
   logic [47:0] got_rd, hold;
   logic [9:0]  b_addr [3];
   logic [47:0] b_data [3];

   initial begin
      vecs[0] = '{2'd0, 1'b1, 10'h3A5, 48'h123456789ABC, 48'h0};
      vecs[1] = '{2'd0, 1'b0, 10'h3A5, 48'h0,            48'h123456789ABC};
      vecs[2] = '{2'd1, 1'b1, 10'h000, 48'hFFFF00005555, 48'h0};
      vecs[3] = '{2'd1, 1'b0, 10'h000, 48'h0,            48'hFFFF00005555};
      vecs[4] = '{2'd2, 1'b1, 10'h3FF, 48'h800000000001, 48'h0};
      vecs[5] = '{2'd2, 1'b0, 10'h3FF, 48'h0,            48'h800000000001};
      vecs[6] = '{2'd3, 1'b1, 10'h155, 48'hA5A5A5A5A5A5, 48'h0};
      vecs[7] = '{2'd3, 1'b0, 10'h155, 48'h0,            48'hA5A5A5A5A5A5};
      vecs[8] = '{2'd3, 1'b0, 10'h3A5, 48'h0,            48'h123456789ABC};
      b_addr = '{10'h020, 10'h021, 10'h022};
      b_data = '{48'h111111111111, 48'h222222222222, 48'h0F0F0F0F0F0F};

      rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; cmd_valid = 1'b0;
      cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 64'(cs_n), 64'd1);
      chk("rst_sclk", 64'(sclk), 64'd0);
      chk("rst_mosi", 64'(mosi), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rw", 64'(rsp_rw), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      #1 chk("ready_before_clk", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("ready_after_clk", 64'(cmd_ready), 64'd1);

      // Table: write/read pairs in all four modes.
      hold  = '0;
      idle0 = idle_err;
      for (int v = 0; v < 9; v++) begin
         wr0  = wr_cnt;
         rsp0 = rsp_cnt;
         do_cmd(vecs[v].mode, vecs[v].rw, vecs[v].addr, vecs[v].wdata, len, got_rw, got_rd, pulse1);
         if (!vecs[v].rw) hold = vecs[v].exp_rdata;
         chk("frame_len", 64'(len), 64'(FRAME_CLK));
         chk("rsp_pulse_1cyc", 64'(pulse1), 64'd1);
         chk("rsp_count", 64'(rsp_cnt - rsp0), 64'd1);
         chk("rsp_rw", 64'(got_rw), 64'(vecs[v].rw));
         chk("rsp_rdata", 64'(got_rd), 64'(hold));
         chk("sclk_edges", 64'(s_edges_last), 64'd120);
         chk("header", 64'(s_hdr_last), 64'({vecs[v].rw, 1'b0, vecs[v].addr}));
         if (vecs[v].rw) begin
            chk("wr_count", 64'(wr_cnt - wr0), 64'd1);
            chk("wr_addr", 64'(wr_addr), 64'(vecs[v].addr));
            chk("wr_data", 64'(wr_data), 64'(vecs[v].wdata));
         end else begin
            chk("rd_no_write", 64'(wr_cnt - wr0), 64'd0);
            chk("rd_mosi_zero", 64'(s_data_last), 64'd0);
         end
      end
      chk("sclk_idle_level", 64'(idle_err - idle0), 64'd0);

      // Back-to-back: cmd_valid held high across three writes.
      wr0  = wr_cnt;
      rsp0 = rsp_cnt;
      @(negedge clk);
      m_cpol = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0;
      @(negedge clk);
      cmd_rw = 1'b1; cmd_addr = b_addr[0]; cmd_wdata = b_data[0]; cmd_valid = 1'b1;
      k = 0; t = 0;
      while (k < 3 && t < 3000) begin
         if (cmd_ready) begin
            acc[k] = cyc;
            k++;
            @(negedge clk); t++;
            if (k < 3) begin
               cmd_addr = b_addr[k]; cmd_wdata = b_data[k];
            end else begin
               cmd_valid = 1'b0;
            end
         end else begin
            @(negedge clk); t++;
         end
      end
      cmd_valid = 1'b0;
      t = 0;
      while ((busy || rsp_cnt - rsp0 < 3) && t < 1000) begin @(negedge clk); t++; end
      chk("b2b_accepts", 64'(k), 64'd3);
      chk("b2b_rsp_count", 64'(rsp_cnt - rsp0), 64'd3);
      chk("b2b_wr_count", 64'(wr_cnt - wr0), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk("b2b_frame_len", 64'(rsp_log[(rsp0 + i) % 16] - acc[i]), 64'(FRAME_CLK));
         chk("b2b_mem", 64'(mem[b_addr[i]]), 64'(b_data[i]));
      end
      chk("b2b_min_gap_ok", 64'(min_gap >= CS_IDLE), 64'd1);
      chk("ready_low_busy", 64'(ready_err), 64'd0);

      // Reset at sclk edge 70 of a write to 0x010.
      wr0  = wr_cnt;
      rsp0 = rsp_cnt;
      @(negedge clk);
      @(negedge clk);
      cmd_rw = 1'b1; cmd_addr = 10'h010; cmd_wdata = 48'hDEADBEEF0123; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      t = 0;
      while (s_edges < 70 && t < 1000) begin @(negedge clk); t++; end
      chk("edge70_reached", 64'(s_edges), 64'd70);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_cs_n", 64'(cs_n), 64'd1);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_mosi", 64'(mosi), 64'd0);
      repeat (5) @(negedge clk);
      chk("rst_mid_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
      chk("rst_mid_no_write", 64'(wr_cnt - wr0), 64'd0);
      chk("rst_mid_rdata", 64'(rsp_rdata), 64'd0);
      rst_n = 1'b1;
      #1 chk("rst_mid_ready0", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("rst_mid_ready1", 64'(cmd_ready), 64'd1);
      do_cmd(2'd0, 1'b0, 10'h010, 48'h0, len, got_rw, got_rd, pulse1);
      chk("post_rst_rdata", 64'(got_rd), 64'd0);
      chk("post_rst_rw", 64'(got_rw), 64'd0);
      chk("post_rst_len", 64'(len), 64'(FRAME_CLK));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
